wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline writeback
//  (MEM_WB output, already muxed by mem_to_reg) and the long-latency mul/div unit (MDU).
//  The pipeline has priority. MDU results that lose arbitration wait in a one-entry hold buffer.
//  A starvation counter stalls the pipeline, freezing MEM_WB and earlier stages, to drain a starved entry.
// PARAMETERS
//  MAX_WAIT  4  pipeline-won cycles tolerated before a forced drain (legal range >= 1)
//  CNT_W     $clog2(MAX_WAIT+1)  width of the wait counter
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   synchronous, active-high reset
//  pipe_reg_write  in   1   pipeline writeback valid (MEM_WB reg_write)
//  pipe_reg_dest   in   5   pipeline destination register
//  pipe_wdata      in   32  pipeline writeback data
//  mdu_valid       in   1   MDU result valid
//  mdu_dest        in   5   MDU destination register
//  mdu_data        in   32  MDU result data
//  mdu_ready       out  1   arbiter can accept an MDU result this cycle
//  rf_write        out  1   register-file write enable
//  rf_dest         out  5   register-file write address
//  rf_wdata        out  32  register-file write data
//  pipe_stall      out  1   freeze MEM_WB and earlier stages this cycle
//  mdu_pending     out  1   hold buffer occupied
// BEHAVIOUR
//  - Reset: clk and rst are fixed as stated above: one clock, synchronous active-high reset.
//    On a clock edge with rst=1: state<=IDLE, buffer cleared, wait_cnt<=0.
//    While rst=1, every output is forced to 0.
//    A buffered result is discarded on reset, including reset mid-WAIT or mid-FORCE.
//  - Pipe slot free: pipe_reg_write==0 OR pipe_reg_dest==0. A write to $0 is a no-op and is
//    never driven to rf.
//  - Accept: an MDU handshake completes when mdu_valid && mdu_ready. mdu_ready=1 only in IDLE.
//    An accepted MDU result with mdu_dest==0 is consumed and dropped.
//  - Output port: rf_* is combinational from state and inputs, giving 0-cycle write latency.
//    When rf_write=0, rf_dest and rf_wdata read 0.
//  - FSM:
//    IDLE: pipe not free -> rf=pipe.
//          Also accepting an MDU result -> capture it in the buffer, wait_cnt<=0, go to WAIT.
//          Pipe free and mdu_valid -> rf=mdu (bypass, no buffering), stay in IDLE.
//          Pipe free and no mdu_valid -> rf_write=0.
//    WAIT: pipe free -> rf=buffer, buffer cleared, go to IDLE.
//          Pipe not free, same dest as buffer -> rf=pipe, buffer squashed, go to IDLE.
//          The MDU entry is defined older, so its value is dead.
//          Pipe not free, different dest -> rf=pipe, wait_cnt+1.
//          When the increment makes wait_cnt==MAX_WAIT, go to FORCE.
//    FORCE: pipe_stall=1; rf=buffer; the pipeline write is suppressed.
//           Because MEM_WB is held, the pipeline write is re-presented next cycle.
//           Buffer cleared, go to IDLE.
//  - pipe_stall is 1 only in FORCE. mdu_pending=1 in WAIT and FORCE.
//  - Width rules: wait_cnt saturates at MAX_WAIT and never wraps. Data passes through
//    unmodified at 32 bits.
//  - Simultaneous events: in a single cycle, a pipeline write plus a new MDU result in IDLE
//    means the pipe writes and the MDU result is buffered. A new MDU result in WAIT or FORCE
//    is not accepted (mdu_ready=0) and the MDU must hold it.
// TESTING
//  1 Reset: rst=1 for 2 cycles with mdu_valid=1, pipe_reg_write=1 -> every output 0.
//    First cycle after reset -> mdu_ready=1, state IDLE.
//  2 Bypass: IDLE, pipe_reg_write=0, mdu dest=5 data=0x1234 -> same cycle rf_write=1 rf_dest=5
//    rf_wdata=0x1234, mdu_pending stays 0.
//  3 Conflict: pipe dest=3 data=0xAA with mdu dest=7 data=0xBB -> rf writes 3/0xAA.
//    Next cycle pipe idle -> rf writes 7/0xBB. Following cycle mdu_ready=1.
//  4 Starvation (MAX_WAIT=4): MDU captured at cycle 0, pipe writes dest 1..6 every cycle ->
//    cycles 1-4 rf=pipe; cycle 5 pipe_stall=1, rf=MDU entry.
//    Cycle 6: pipe_stall=0, held pipe write reaches rf.
//  5 WAW squash: buffer holds dest 9 = 0x55, pipe writes dest 9 = 0x66 -> rf writes 9/0x66.
//    Next state IDLE; 0x55 never appears on rf.
//  6 Reset mid-operation: rst=1 while in WAIT with wait_cnt=2 -> next cycle IDLE,
//    mdu_pending=0. The buffered value never appears on rf.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over the MDU.
// Ports: clk/rst; pipe_* writeback in; mdu_* result in with mdu_ready;
//        rf_* write port out; pipe_stall (freeze MEM_WB and earlier); mdu_pending.
// Latency: rf_* is combinational (0-cycle). Backpressure: mdu_ready=0 while an
// MDU entry is held; the pipeline is stalled for one cycle to drain a starved entry.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_reg_write,
  input  logic [4:0]  pipe_reg_dest,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_dest,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_write,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic        mdu_pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state, state_nxt;
  logic [4:0]       buf_dest, buf_dest_nxt;
  logic [31:0]      buf_data, buf_data_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  // Writes to $0 are no-ops, so they leave the port free.
  logic pipe_busy;
  assign pipe_busy = pipe_reg_write && (pipe_reg_dest != 5'd0);

  logic       wr;
  logic [4:0] dest;
  logic [31:0] wdata;
  logic       ready;
  logic       stall;
  logic       pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      buf_dest <= 5'd0;
      buf_data <= 32'd0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      buf_dest <= buf_dest_nxt;
      buf_data <= buf_data_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    buf_dest_nxt = buf_dest;
    buf_data_nxt = buf_data;
    wait_cnt_nxt = wait_cnt;
    wr           = 1'b0;
    dest         = 5'd0;
    wdata        = 32'd0;
    ready        = 1'b0;
    stall        = 1'b0;
    pending      = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (pipe_busy) begin
          wr    = 1'b1;
          dest  = pipe_reg_dest;
          wdata = pipe_wdata;
          // A result aimed at $0 is accepted and simply dropped.
          if (mdu_valid && (mdu_dest != 5'd0)) begin
            buf_dest_nxt = mdu_dest;
            buf_data_nxt = mdu_data;
            wait_cnt_nxt = '0;
            state_nxt    = WAIT;
          end
        end else if (mdu_valid && (mdu_dest != 5'd0)) begin
          wr    = 1'b1;
          dest  = mdu_dest;
          wdata = mdu_data;
        end
      end

      WAIT: begin
        pending = 1'b1;
        if (!pipe_busy) begin
          wr           = 1'b1;
          dest         = buf_dest;
          wdata        = buf_data;
          buf_dest_nxt = 5'd0;
          buf_data_nxt = 32'd0;
          state_nxt    = IDLE;
        end else begin
          wr    = 1'b1;
          dest  = pipe_reg_dest;
          wdata = pipe_wdata;
          if (pipe_reg_dest == buf_dest) begin
            // The held MDU result is older, so the pipeline write kills it.
            buf_dest_nxt = 5'd0;
            buf_data_nxt = 32'd0;
            state_nxt    = IDLE;
          end else begin
            if (wait_cnt != MAX_CNT) begin
              wait_cnt_nxt = wait_cnt + 1'b1;
            end
            if (wait_cnt_nxt == MAX_CNT) begin
              state_nxt = FORCE;
            end
          end
        end
      end

      FORCE: begin
        // MEM_WB is frozen, so the suppressed pipeline write comes back next cycle.
        pending      = 1'b1;
        stall        = 1'b1;
        wr           = 1'b1;
        dest         = buf_dest;
        wdata        = buf_data;
        buf_dest_nxt = 5'd0;
        buf_data_nxt = 32'd0;
        state_nxt    = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Every output is held low while reset is asserted.
  assign mdu_ready   = ready   && !rst;
  assign rf_write    = wr      && !rst;
  assign rf_dest     = rst ? 5'd0  : dest;
  assign rf_wdata    = rst ? 32'd0 : wdata;
  assign pipe_stall  = stall   && !rst;
  assign mdu_pending = pending && !rst;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter with MAX_WAIT=4.
// Inputs change 2 time units after posedge, outputs sampled 1 unit later.
// Every check goes through chk() which counts comparisons and mismatches.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_reg_write;
  logic [4:0]  pipe_reg_dest;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_write;
  logic [4:0]  rf_dest;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic        mdu_pending;

  int n_cmp;
  int n_bad;

  wb_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_reg_write (pipe_reg_write),
    .pipe_reg_dest  (pipe_reg_dest),
    .pipe_wdata     (pipe_wdata),
    .mdu_valid      (mdu_valid),
    .mdu_dest       (mdu_dest),
    .mdu_data       (mdu_data),
    .mdu_ready      (mdu_ready),
    .rf_write       (rf_write),
    .rf_dest        (rf_dest),
    .rf_wdata       (rf_wdata),
    .pipe_stall     (pipe_stall),
    .mdu_pending    (mdu_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] pd, input logic [31:0] pdat,
                       input logic mv, input logic [4:0] md, input logic [31:0] mdat);
    pipe_reg_write = pw;
    pipe_reg_dest  = pd;
    pipe_wdata     = pdat;
    mdu_valid      = mv;
    mdu_dest       = md;
    mdu_data       = mdat;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_rf(input string tag, input logic w, input logic [4:0] d, input logic [31:0] v);
    chk({tag, ".rf_write"}, 32'(rf_write), 32'(w));
    chk({tag, ".rf_dest"},  32'(rf_dest),  32'(d));
    chk({tag, ".rf_wdata"}, rf_wdata,      v);
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic stl, input logic pnd);
    chk({tag, ".mdu_ready"},   32'(mdu_ready),   32'(rdy));
    chk({tag, ".pipe_stall"},  32'(pipe_stall),  32'(stl));
    chk({tag, ".mdu_pending"}, 32'(mdu_pending), 32'(pnd));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // 1: reset with active inputs forces all outputs low
    rst = 1'b1;
    drive(1, 5'd3, 32'hDEAD, 1, 5'd7, 32'hBEEF);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(1, 5'd3, 32'hDEAD, 1, 5'd7, 32'hBEEF);
      chk_rf("rst", 0, 5'd0, 32'd0);
      chk_ctl("rst", 0, 0, 0);
    end
    next_cycle();
    rst = 1'b0;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_ctl("post_rst", 1, 0, 0);
    chk_rf("post_rst", 0, 5'd0, 32'd0);

    // 2: bypass when pipe idle
    drive(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
    chk_rf("bypass", 1, 5'd5, 32'h1234);
    chk_ctl("bypass", 1, 0, 0);
    next_cycle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_ctl("bypass_after", 1, 0, 0);

    // bypass to $0 is dropped
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h99);
    chk_rf("mdu_zero", 0, 5'd0, 32'd0);
    next_cycle();

    // pipe write to $0 counts as free: MDU bypasses
    drive(1, 5'd0, 32'h77, 1, 5'd4, 32'h44);
    chk_rf("pipe_zero", 1, 5'd4, 32'h44);
    next_cycle();

    // 3: conflict, then drain
    drive(1, 5'd3, 32'hAA, 1, 5'd7, 32'hBB);
    chk_rf("conf0", 1, 5'd3, 32'hAA);
    chk_ctl("conf0", 1, 0, 0);
    next_cycle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_rf("conf1", 1, 5'd7, 32'hBB);
    chk_ctl("conf1", 0, 0, 1);
    next_cycle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_rf("conf2", 0, 5'd0, 32'd0);
    chk_ctl("conf2", 1, 0, 0);
    next_cycle();

    // busy pipe with MDU result to $0: consumed, nothing buffered
    drive(1, 5'd3, 32'h1, 1, 5'd0, 32'h9);
    chk_rf("busy_mdu_zero", 1, 5'd3, 32'h1);
    next_cycle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_ctl("busy_mdu_zero_after", 1, 0, 0);
    next_cycle();

    // 4: starvation, forced drain after 4 pipeline-won cycles
    drive(1, 5'd10, 32'h100, 1, 5'd20, 32'hC0DE);
    chk_rf("starve0", 1, 5'd10, 32'h100);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 32'h200 + 32'(i), 1, 5'd21, 32'hF00D);
      chk_rf("starve_pipe", 1, 5'(i), 32'h200 + 32'(i));
      chk_ctl("starve_pipe", 0, 0, 1);
      next_cycle();
    end
    drive(1, 5'd5, 32'h205, 0, 5'd0, 32'd0);
    chk_rf("starve_force", 1, 5'd20, 32'hC0DE);
    chk_ctl("starve_force", 0, 1, 1);
    next_cycle();
    drive(1, 5'd5, 32'h205, 0, 5'd0, 32'd0);
    chk_rf("starve_replay", 1, 5'd5, 32'h205);
    chk_ctl("starve_replay", 1, 0, 0);
    next_cycle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    next_cycle();

    // 5: WAW squash
    drive(1, 5'd2, 32'h11, 1, 5'd9, 32'h55);
    chk_rf("waw0", 1, 5'd2, 32'h11);
    next_cycle();
    drive(1, 5'd9, 32'h66, 0, 5'd0, 32'd0);
    chk_rf("waw1", 1, 5'd9, 32'h66);
    chk_ctl("waw1", 0, 0, 1);
    next_cycle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_rf("waw2", 0, 5'd0, 32'd0);
    chk_ctl("waw2", 1, 0, 0);
    next_cycle();

    // 6: reset mid-WAIT with wait_cnt=2 discards the entry
    drive(1, 5'd2, 32'h1, 1, 5'd12, 32'h77);
    next_cycle();
    drive(1, 5'd4, 32'h2, 0, 5'd0, 32'd0);
    next_cycle();
    drive(1, 5'd6, 32'h3, 0, 5'd0, 32'd0);
    chk_ctl("mid_wait", 0, 0, 1);
    next_cycle();
    rst = 1'b1;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_rf("mid_rst", 0, 5'd0, 32'd0);
    chk_ctl("mid_rst", 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk_rf("after_mid_rst", 0, 5'd0, 32'd0);
    chk_ctl("after_mid_rst", 1, 0, 0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
